freq_meter_4ch: RTL and testbench

Four-channel gated edge counter that measures the rate of up to four slow, asynchronous toggling signals, such as per-domain counter MSBs, in a single system clock domain. Each channel is synchronized and its rising edges are counted over a programmable gate window. The four results are then latched together and flagged valid for one cycle. The block is the on-chip checker at the receiving end of the multi-clock counter designs used in the design-flow tests.

---
 rtl/freq_meter_4ch.sv | 153 +++++++++++++++
 tb/tb_freq_meter_4ch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_4ch.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_4ch
// Purpose  : Four-channel gated rising-edge counter. Each asynchronous input
//            is synchronized, its rising edges are counted over a window of
//            GATE_CYCLES clk cycles, and the four results are latched
//            together and flagged with a one-cycle valid pulse.
// Ports    : clk     - system clock, all logic on its rising edge
//            rst     - asynchronous active-high reset
//            sig_in  - [3:0] asynchronous inputs, one per channel
//            start   - measurement request, sampled only in IDLE
//            busy    - high from the cycle after start is accepted to DONE
//            valid   - one-cycle pulse, count/ovf are new in that cycle
//            count   - [4*CNT_W-1:0] latched counts, ch n at [n*CNT_W +: CNT_W]
//            ovf     - [3:0] latched per-channel saturation flags
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter_4ch #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 valid,
    output logic [4*CNT_W-1:0]   count,
    output logic [3:0]           ovf
);

    localparam int                c_win_w   = $clog2(GATE_CYCLES + 1);
    localparam logic [c_win_w-1:0] c_win_load = c_win_w'(GATE_CYCLES);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [1:0]        c_arm_last = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_arm_cnt;
    logic [c_win_w-1:0]   r_win;

    logic [3:0]           r_sync1;
    logic [3:0]           r_sync2;
    logic [3:0]           r_prev;
    logic [3:0]           w_edge;

    logic [4*CNT_W-1:0]   r_run;
    logic [3:0]           r_run_ovf;
    logic [4*CNT_W-1:0]   w_run_nxt;
    logic [3:0]           w_ovf_nxt;
    logic [3:0]           w_sat;

    // ------------------------------------------------------------------------
    // Input path. The synchronizers run continuously; the three ARM cycles
    // exist so that sync1, sync2 and prev are all refilled from the live
    // inputs before counting starts, so an edge seen during IDLE can never
    // leak into the window.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
            r_prev  <= 4'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    // ------------------------------------------------------------------------
    // Per-channel saturating next-count. Computed combinationally so that an
    // edge in the last GATE cycle is included in the latched result.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 4; i++) begin : g_ch
            assign w_sat[i] = (r_run[i*CNT_W +: CNT_W] == c_cnt_max);
            assign w_run_nxt[i*CNT_W +: CNT_W] =
                (w_edge[i] && !w_sat[i]) ? r_run[i*CNT_W +: CNT_W] + CNT_W'(1)
                                         : r_run[i*CNT_W +: CNT_W];
            assign w_ovf_nxt[i] = r_run_ovf[i] | (w_edge[i] & w_sat[i]);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arm_cnt <= 2'd0;
            r_win     <= '0;
            r_run     <= '0;
            r_run_ovf <= 4'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            count     <= '0;
            ovf       <= 4'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_ARM;
                        r_arm_cnt <= 2'd0;
                        busy      <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_run     <= '0;
                    r_run_ovf <= 4'b0;
                    r_win     <= c_win_load;
                    r_arm_cnt <= r_arm_cnt + 2'd1;
                    if (r_arm_cnt == c_arm_last) begin
                        r_state <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    r_run     <= w_run_nxt;
                    r_run_ovf <= w_ovf_nxt;
                    // Window counter stops at 1; the last GATE cycle is the
                    // one in which it reads 1.
                    if (r_win == c_win_w'(1)) begin
                        count   <= w_run_nxt;
                        ovf     <= w_ovf_nxt;
                        valid   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_win <= r_win - c_win_w'(1);
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_4ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter_4ch
// Purpose  : Scoreboard bench for freq_meter_4ch. Stimulus tasks plan each
//            window's input waveforms, derive the expected counts from the
//            rising edges that fall inside the gate window, and queue them;
//            a monitor pops and compares on every valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter_4ch;

    localparam int G    = 64;
    localparam int W    = 4;
    localparam int MAXC = (1 << W) - 1;
    localparam int PER  = G + 5;       // start-to-start spacing when start is held
    localparam int NASYNC = 400;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       sig_drv = 4'b0;
    logic             async_sig = 1'b0;
    logic             async_en = 1'b0;
    logic [3:0]       sig_in;
    logic             busy;
    logic             valid;
    logic [4*W-1:0]   count;
    logic [3:0]       ovf;

    assign sig_in = async_en ? {sig_drv[3:2], async_sig, sig_drv[0]} : sig_drv;

    freq_meter_4ch #(
        .GATE_CYCLES (G),
        .CNT_W       (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .start  (start),
        .busy   (busy),
        .valid  (valid),
        .count  (count),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Unrelated clock: period 104 ns against a 10 ns clk, i.e. about clk/10.4.
    initial begin
        #3;
        forever #52 async_sig = ~async_sig;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int              cyc;
        logic [3:0][7:0] lo;
        logic [3:0][7:0] hi;
        logic [3:0]      ovf;
    } exp_t;

    exp_t q[$];

    // Waveform plan: per==0 means a static level, otherwise a square wave
    // whose value in cycle r is high for the first per/2 cycles of each period.
    int   per[4];
    int   ph[4];
    bit   lvl[4];

    function automatic bit wave(input int c, input int r);
        if (per[c] == 0) return lvl[c];
        return (((r + ph[c]) % per[c]) < (per[c] / 2));
    endfunction

    // A rise first sampled at the clk edge ending cycle r reaches the edge
    // detector two cycles later, so it is counted when r+2 lies in GATE.
    function automatic int rises(input int c, input int r0, input int r1);
        int n = 0;
        for (int r = r0; r <= r1; r++)
            if (wave(c, r) && !wave(c, r - 1)) n++;
        return n;
    endfunction

    task automatic check(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    bit             hold_known = 1'b1;
    logic [4*W-1:0] hold_cnt = '0;
    logic [3:0]     hold_ovf = 4'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_known = 1'b1;
            hold_cnt   = '0;
            hold_ovf   = 4'b0;
        end else if (valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0, 0);
            end else begin
                e = q.pop_front();
                check("valid_cycle", cyc, e.cyc, e.cyc);
                for (int c = 0; c < 4; c++)
                    check($sformatf("count_ch%0d", c), int'(count[c*W +: W]),
                          int'(e.lo[c]), int'(e.hi[c]));
                check("ovf", int'(ovf), int'(e.ovf), int'(e.ovf));
                hold_known = (e.lo == e.hi);
                for (int c = 0; c < 4; c++)
                    hold_cnt[c*W +: W] = e.lo[c][W-1:0];
                hold_ovf = e.ovf;
            end
        end else if (hold_known) begin
            check("count_hold", int'(count), int'(hold_cnt), int'(hold_cnt));
            check("ovf_hold", int'(ovf), int'(hold_ovf), int'(hold_ovf));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic run_windows(input int nwin, input bit held, input int extra_r,
                               input bit amode);
        int   t0;
        int   base;
        int   n;
        int   m;
        exp_t e;
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < nwin; k++) begin
            base  = k * PER;
            e     = '0;
            e.cyc = t0 + base + 4 + G;
            for (int c = 0; c < 4; c++) begin
                if (amode && c == 1) begin
                    e.lo[c] = 8'(G / 10 - 1);
                    e.hi[c] = 8'(G / 10 + 1);
                end else begin
                    n = rises(c, base + 2, base + 1 + G);
                    e.lo[c]  = 8'((n > MAXC) ? MAXC : n);
                    e.hi[c]  = e.lo[c];
                    e.ovf[c] = (n > MAXC);
                end
            end
            q.push_back(e);
        end
        for (int r = 0; r <= nwin * PER; r++) begin
            start = (held && r < nwin * PER) || r == 0 || r == extra_r;
            for (int c = 0; c < 4; c++) sig_drv[c] = wave(c, r);
            m = r % PER;
            if (m == 0)     check("busy_idle", int'(busy), 0, 0);
            if (m == 1)     check("busy_arm",  int'(busy), 1, 1);
            if (m == 4 + G) check("busy_done", int'(busy), 1, 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
        per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
        for (int c = 0; c < 4; c++) begin
            ph[c]  = $urandom_range(0, 31);
            lvl[c] = 1'b0;
        end
    endtask

    task automatic run_reset_mid();
        for (int r = 0; r < 33; r++) begin
            start = (r == 0);
            for (int c = 0; c < 4; c++) sig_drv[c] = wave(c, r);
            @(posedge clk); #1;
        end
        // Cycle 30 of GATE.
        rst = 1'b1;
        #1;
        check("rst_busy",  int'(busy),  0, 0);
        check("rst_valid", int'(valid), 0, 0);
        check("rst_count", int'(count), 0, 0);
        check("rst_ovf",   int'(ovf),   0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (G + 10) @(posedge clk);
        #1;
        check("busy_after_rst", int'(busy), 0, 0);
    endtask

    initial begin
        set_plan(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  int'(busy),  0, 0);
        check("reset_valid", int'(valid), 0, 0);
        check("reset_count", int'(count), 0, 0);
        check("reset_ovf",   int'(ovf),   0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single window, ch0 period 8, then back-to-back with start held.
        set_plan(8, 0, 0, 0);
        run_windows(1, 1'b0, -1, 1'b0);
        run_windows(3, 1'b1, -1, 1'b0);

        // Mixed rates; ch0 (period 4, 16 edges) saturates at 15.
        set_plan(4, 8, 16, 32);
        run_windows(1, 1'b0, -1, 1'b0);

        // Saturation on ch2 only.
        set_plan(0, 0, 4, 0);
        run_windows(1, 1'b0, -1, 1'b0);

        // Toggle everything in IDLE, then static inputs and a mid-GATE start.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) sig_drv = 4'($urandom_range(0, 15));
        end
        set_plan(0, 0, 0, 0);
        for (int c = 0; c < 4; c++) lvl[c] = 1'($urandom_range(0, 1));
        run_windows(1, 1'b0, 4 + G / 2, 1'b0);

        // Result is nonzero going into the reset, so clearing is observable.
        set_plan(0, 0, 4, 8);
        run_windows(1, 1'b0, -1, 1'b0);
        run_reset_mid();
        run_windows(1, 1'b0, -1, 1'b0);

        // Randomized plans.
        for (int i = 0; i < 12; i++) begin
            bit h;
            for (int c = 0; c < 4; c++) begin
                per[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(4, 24));
                ph[c]  = $urandom_range(0, 23);
                lvl[c] = 1'($urandom_range(0, 1));
            end
            h = 1'($urandom_range(0, 1));
            run_windows(h ? 2 : 1, h, -1, 1'b0);
        end

        // Asynchronous ch1, back-to-back windows.
        set_plan(0, 0, 0, 0);
        async_en = 1'b1;
        run_windows(NASYNC, 1'b1, -1, 1'b1);
        async_en = 1'b0;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
